ex_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage ARM core, reading the ID/EX register outputs, the decode stage's source-register fields and the EX-stage branch decision. It detects load-use hazards and taken branches. It drives PC/IF-ID write-enables, the ID/EX bubble select (zero control bits) and the IF/ID flush. A small FSM stretches stalls and flushes over multi-cycle penalties, and saturating counters record stall and flush cycles for performance debug.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/sat_counter.sv | 32 +++
 rtl/ex_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_ex_hazard_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the ARM core pipeline control logic.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } hz_state_t;

  typedef logic [4:0] reg_idx_t;

  // X31 reads as zero, so a write to it can never feed a later instruction.
  localparam reg_idx_t XZR = 5'd31;

endpackage : cpu_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/ex_hazard_ctrl.sv
// Load-use and taken-branch hazard controller: zero-cycle detection, with an FSM
// that stretches stalls and flushes over multi-cycle penalties.
module ex_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memRead_EX,
  input  logic             RegWrite_EX,
  input  reg_idx_t         targetReg_EX,
  input  reg_idx_t         id_rn,
  input  reg_idx_t         id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             br_taken_EX,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int MAX_PEN = (LOAD_STALL > BR_PENALTY) ? LOAD_STALL : BR_PENALTY;
  localparam int REM_W   = $clog2(MAX_PEN + 1);

  hz_state_t        state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             lu;

  assign lu = memRead_EX && RegWrite_EX && (targetReg_EX != XZR) &&
              ((id_uses_rn && (id_rn == targetReg_EX)) ||
               (id_uses_rm && (id_rm == targetReg_EX)));

  // NOTE: every output and next-state signal gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (br_taken_EX) begin
          idex_bubble = 1'b1;
          ifid_flush  = 1'b1;
          if (BR_PENALTY > 1) begin
            state_d = FLUSH;
            rem_d   = REM_W'(BR_PENALTY - 1);
          end
        end else if (lu) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = STALL;
            rem_d   = REM_W'(LOAD_STALL - 1);
          end
        end
      end

      // The load has already left EX, so lu and branches are not re-evaluated here.
      STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        rem_d       = rem_q - REM_W'(1);
        if (rem_q == REM_W'(1)) begin
          state_d = RUN;
        end
      end

      FLUSH: begin
        idex_bubble = 1'b1;
        ifid_flush  = 1'b1;
        rem_d       = rem_q - REM_W'(1);
        if (rem_q == REM_W'(1)) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~pc_write),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifid_flush),
    .count (flush_count)
  );

endmodule : ex_hazard_ctrl

// File: tb/tb_ex_hazard_ctrl.sv
// Directed-vector bench for ex_hazard_ctrl across three parameter sets sharing one stimulus bus.
module tb_ex_hazard_ctrl;

  localparam logic [3:0] RUN_V   = 4'b1100; // {pc_write, ifid_write, idex_bubble, ifid_flush}
  localparam logic [3:0] STALL_V = 4'b0010;
  localparam logic [3:0] FLUSH_V = 4'b1111;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_rd, reg_wr, br;
  logic [4:0] tgt, rn, rm;
  logic       u_rn, u_rm;

  logic        pw_a, iw_a, bb_a, fl_a;
  logic [31:0] sc_a, fc_a;
  logic        pw_b, iw_b, bb_b, fl_b;
  logic [31:0] sc_b, fc_b;
  logic        pw_c, iw_c, bb_c, fl_c;
  logic [3:0]  sc_c, fc_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.LOAD_STALL(1), .BR_PENALTY(2), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .memRead_EX(mem_rd), .RegWrite_EX(reg_wr),
    .targetReg_EX(tgt), .id_rn(rn), .id_rm(rm), .id_uses_rn(u_rn), .id_uses_rm(u_rm),
    .br_taken_EX(br), .pc_write(pw_a), .ifid_write(iw_a), .idex_bubble(bb_a),
    .ifid_flush(fl_a), .stall_count(sc_a), .flush_count(fc_a));

  ex_hazard_ctrl #(.LOAD_STALL(3), .BR_PENALTY(2), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .memRead_EX(mem_rd), .RegWrite_EX(reg_wr),
    .targetReg_EX(tgt), .id_rn(rn), .id_rm(rm), .id_uses_rn(u_rn), .id_uses_rm(u_rm),
    .br_taken_EX(br), .pc_write(pw_b), .ifid_write(iw_b), .idex_bubble(bb_b),
    .ifid_flush(fl_b), .stall_count(sc_b), .flush_count(fc_b));

  ex_hazard_ctrl #(.LOAD_STALL(1), .BR_PENALTY(2), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .memRead_EX(mem_rd), .RegWrite_EX(reg_wr),
    .targetReg_EX(tgt), .id_rn(rn), .id_rm(rm), .id_uses_rn(u_rn), .id_uses_rm(u_rm),
    .br_taken_EX(br), .pc_write(pw_c), .ifid_write(iw_c), .idex_bubble(bb_c),
    .ifid_flush(fl_c), .stall_count(sc_c), .flush_count(fc_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic m, input logic w, input logic [4:0] t,
                        input logic [4:0] a, input logic ua,
                        input logic [4:0] b, input logic ub, input logic bt);
    mem_rd = m; reg_wr = w; tgt = t; rn = a; u_rn = ua; rm = b; u_rm = ub; br = bt;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Leave the active edge behind, then let the combinational outputs settle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #2;
    chk("reset_outs_a", 32'({pw_a, iw_a, bb_a, fl_a}), 32'(RUN_V));
    chk("reset_stall_a", sc_a, 32'd0);
    chk("reset_flush_a", fc_a, 32'd0);
    next_cycle();
    reset = 1'b1;

    // Load-use on rn, single-cycle penalty.
    set_in(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    #2 chk("lu_rn_outs", 32'({pw_a, iw_a, bb_a, fl_a}), 32'(STALL_V));
    next_cycle();
    idle();
    #2 chk("lu_rn_back_run", 32'({pw_a, iw_a, bb_a, fl_a}), 32'(RUN_V));
    chk("lu_rn_stall_cnt", sc_a, 32'd1);
    next_cycle();

    // Exemptions and the rm path.
    set_in(1'b1, 1'b1, 5'd31, 5'd31, 1'b1, 5'd0, 1'b0, 1'b0);
    #2 chk("xzr_no_stall", 32'({pw_a, iw_a, bb_a, fl_a}), 32'(RUN_V));
    next_cycle();
    set_in(1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0);
    #2 chk("rm_unused_no_stall", 32'({pw_a, iw_a, bb_a, fl_a}), 32'(RUN_V));
    next_cycle();
    set_in(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
    #2 chk("no_load_no_stall", 32'({pw_a, iw_a, bb_a, fl_a}), 32'(RUN_V));
    next_cycle();
    set_in(1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    #2 chk("lu_rm_outs", 32'({pw_a, iw_a, bb_a, fl_a}), 32'(STALL_V));
    next_cycle();
    idle();
    #2 chk("exempt_stall_cnt", sc_a, 32'd2);
    next_cycle();

    // Taken branch, second br_taken_EX lands in FLUSH and is ignored.
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #2 chk("br_cyc1", 32'({pw_a, iw_a, bb_a, fl_a}), 32'(FLUSH_V));
    next_cycle();
    #2 chk("br_cyc2", 32'({pw_a, iw_a, bb_a, fl_a}), 32'(FLUSH_V));
    next_cycle();
    idle();
    #2 chk("br_back_run", 32'({pw_a, iw_a, bb_a, fl_a}), 32'(RUN_V));
    chk("br_flush_cnt", fc_a, 32'd2);
    next_cycle();

    // Branch and load-use together: branch wins, lu stays ignored in FLUSH.
    set_in(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1);
    #2 chk("both_cyc1", 32'({pw_a, iw_a, bb_a, fl_a}), 32'(FLUSH_V));
    next_cycle();
    br = 1'b0;
    #2 chk("both_cyc2", 32'({pw_a, iw_a, bb_a, fl_a}), 32'(FLUSH_V));
    next_cycle();
    idle();
    #2 chk("both_stall_cnt", sc_a, 32'd2);
    chk("both_flush_cnt", fc_a, 32'd4);
    next_cycle();

    // LOAD_STALL=3 instance: full penalty, then reset in the second stall cycle.
    reset = 1'b0;
    #1 reset = 1'b1;
    set_in(1'b1, 1'b1, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    #1 chk("ls3_cyc1", 32'({pw_b, iw_b, bb_b, fl_b}), 32'(STALL_V));
    next_cycle();
    idle();
    #2 chk("ls3_cyc2", 32'({pw_b, iw_b, bb_b, fl_b}), 32'(STALL_V));
    next_cycle();
    #2 chk("ls3_cyc3", 32'({pw_b, iw_b, bb_b, fl_b}), 32'(STALL_V));
    next_cycle();
    #2 chk("ls3_done", 32'({pw_b, iw_b, bb_b, fl_b}), 32'(RUN_V));
    chk("ls3_stall_cnt", sc_b, 32'd3);
    next_cycle();
    set_in(1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
    #2 chk("ls3r_cyc1", 32'({pw_b, iw_b, bb_b, fl_b}), 32'(STALL_V));
    next_cycle();
    idle();
    #1 chk("ls3r_cyc2", 32'({pw_b, iw_b, bb_b, fl_b}), 32'(STALL_V));
    reset = 1'b0;
    #1;
    chk("ls3r_async_outs", 32'({pw_b, iw_b, bb_b, fl_b}), 32'(RUN_V));
    chk("ls3r_async_stall", sc_b, 32'd0);
    chk("ls3r_async_flush", fc_a, 32'd0);
    next_cycle();
    reset = 1'b1;
    #2 chk("ls3r_after_release", 32'({pw_b, iw_b, bb_b, fl_b}), 32'(RUN_V));
    next_cycle();

    // CNT_W=4 instance: 20 back-to-back load-use stalls saturate at 15.
    reset = 1'b0;
    #1 reset = 1'b1;
    set_in(1'b1, 1'b1, 5'd12, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (i == 14) chk("sat_cnt_14", 32'(sc_c), 32'd14);
      if (i == 17) chk("sat_cnt_17", 32'(sc_c), 32'd15);
      if (i == 19) chk("sat_outs_19", 32'({pw_c, iw_c, bb_c, fl_c}), 32'(STALL_V));
      next_cycle();
    end
    idle();
    #2 chk("sat_hold", 32'(sc_c), 32'd15);
    next_cycle();
    #2 chk("sat_hold_idle", 32'(sc_c), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ex_hazard_ctrl
